// File: rtl/edge_overlay_stats.sv
// edge_overlay_stats: aligns the RGB stream with Sobel edge magnitudes. It drives
// the display pixel in one of four view modes. It also gathers per-frame edge count
// and bounding box, which are published once per frame.
module edge_overlay_stats #(
    parameter int unsigned DELAY     = 2,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter logic [23:0] OVL_COLOR = 24'hFF0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [12:0] col,
    input  logic [12:0] row,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic [7:0]  edge_in,
    input  logic [1:0]  mode,
    input  logic [7:0]  thresh,
    output logic [7:0]  r_out,
    output logic [7:0]  g_out,
    output logic [7:0]  b_out,
    output logic        out_valid,
    output logic [19:0] edge_count,
    output logic [12:0] x_min,
    output logic [12:0] x_max,
    output logic [12:0] y_min,
    output logic [12:0] y_max,
    output logic        stats_valid
);

    localparam int unsigned PW   = 8;
    localparam int unsigned CW   = 13;
    localparam int unsigned CNTW = 20;
    localparam int unsigned RGBW = 3 * PW;
    // Each stage carries a valid flag so that cleared stages never look like pixel (0,0).
    localparam int unsigned DW   = 1 + RGBW + 2 * CW;
    localparam int unsigned DLW  = DELAY * DW;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DLW-1:0]     r_dl;
    logic [DLW-1:0]     w_dl_nxt;
    logic [DW-1:0]      w_tap;
    logic               w_d_vld;
    logic [RGBW-1:0]    w_d_rgb;
    logic [CW-1:0]      w_d_col;
    logic [CW-1:0]      w_d_row;

    logic               w_act;
    logic               w_fs;
    logic               w_eof;
    logic               w_hit;
    logic [PW-1:0]      w_thr;
    logic [RGBW-1:0]    w_pix;

    logic               w_init;
    logic               w_acc;
    logic               w_pub;

    logic [PW-1:0]      r_thr_q;
    logic [CNTW-1:0]    r_cnt;
    logic               r_any;
    logic [CW-1:0]      r_xmin;
    logic [CW-1:0]      r_xmax;
    logic [CW-1:0]      r_ymin;
    logic [CW-1:0]      r_ymax;

    // Next delay-line contents: oldest stage falls off the top, new pixel enters at stage 0.
    always_comb begin
        w_dl_nxt           = r_dl << DW;
        w_dl_nxt[DW-1:0]   = {1'b1, r, g, b, col, row};
    end

    // Delay line register, advancing only on pixel steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dl <= '0;
        end else if (pix_en) begin
            r_dl <= w_dl_nxt;
        end
    end

    assign w_tap = r_dl[DLW-1 -: DW];
    assign {w_d_vld, w_d_rgb, w_d_col, w_d_row} = w_tap;

    assign w_act = w_d_vld && (w_d_col < CW'(H_ACTIVE)) && (w_d_row < CW'(V_ACTIVE));
    assign w_fs  = w_d_vld && (w_d_col == '0) && (w_d_row == '0);
    assign w_eof = w_d_vld && (w_d_col == CW'(H_ACTIVE - 1)) && (w_d_row == CW'(V_ACTIVE - 1));
    // The frame-start pixel belongs to the new frame, so it is judged by the new threshold.
    assign w_thr = w_fs ? thresh : r_thr_q;
    assign w_hit = w_act && (edge_in >= w_thr);

    // Display pixel selection for the delayed pixel.
    always_comb begin
        w_pix = '0;
        if (w_act) begin
            case (mode)
                2'd0:    w_pix = w_d_rgb;
                2'd1:    w_pix = {edge_in, edge_in, edge_in};
                2'd2:    w_pix = w_hit ? OVL_COLOR : w_d_rgb;
                default: w_pix = w_hit ? 24'hFFFFFF : 24'h000000;
            endcase
        end
    end

    // Output pixel register; holds its value when no pixel step occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
            out_valid <= 1'b0;
        end else if (pix_en) begin
            {r_out, g_out, b_out} <= w_pix;
            out_valid             <= w_act;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Stats FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stats FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (pix_en && w_fs) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (pix_en) begin
                    if (w_fs) begin
                        w_state_nxt = S_ACCUM;
                    end else if (w_eof) begin
                        w_state_nxt = S_PUBLISH;
                    end
                end
            end
            S_PUBLISH: begin
                w_state_nxt = (pix_en && w_fs) ? S_ACCUM : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stats FSM control decode.
    always_comb begin
        w_init = 1'b0;
        w_acc  = 1'b0;
        w_pub  = 1'b0;
        if (pix_en && w_fs) begin
            w_init = 1'b1;
        end
        if (pix_en && (r_state == S_ACCUM) && !w_fs) begin
            w_acc = 1'b1;
        end
        if (r_state == S_PUBLISH) begin
            w_pub = 1'b1;
        end
    end

    // Per-frame accumulation of threshold, edge count and bounding box.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_thr_q <= '0;
            r_cnt   <= '0;
            r_any   <= 1'b0;
            r_xmin  <= '0;
            r_xmax  <= '0;
            r_ymin  <= '0;
            r_ymax  <= '0;
        end else if (w_init) begin
            r_thr_q <= thresh;
            r_cnt   <= CNTW'(w_hit);
            r_any   <= w_hit;
            r_xmin  <= w_d_col;
            r_xmax  <= w_d_col;
            r_ymin  <= w_d_row;
            r_ymax  <= w_d_row;
        end else if (w_acc && w_hit) begin
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
            r_any <= 1'b1;
            if (!r_any) begin
                r_xmin <= w_d_col;
                r_xmax <= w_d_col;
                r_ymin <= w_d_row;
                r_ymax <= w_d_row;
            end else begin
                if (w_d_col < r_xmin) r_xmin <= w_d_col;
                if (w_d_col > r_xmax) r_xmax <= w_d_col;
                if (w_d_row < r_ymin) r_ymin <= w_d_row;
                if (w_d_row > r_ymax) r_ymax <= w_d_row;
            end
        end
    end

    // Publish registers; an empty frame reports a zero bounding box.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_count  <= '0;
            x_min       <= '0;
            x_max       <= '0;
            y_min       <= '0;
            y_max       <= '0;
            stats_valid <= 1'b0;
        end else if (w_pub) begin
            edge_count  <= r_cnt;
            x_min       <= r_any ? r_xmin : '0;
            x_max       <= r_any ? r_xmax : '0;
            y_min       <= r_any ? r_ymin : '0;
            y_max       <= r_any ? r_ymax : '0;
            stats_valid <= 1'b1;
        end else begin
            stats_valid <= 1'b0;
        end
    end

endmodule

// File: doc/edge_overlay_stats.md
Name: edge_overlay_stats

Overview:
- Downstream consumer of the Sobel edge-magnitude stage.
- Takes the 8-bit edge value for each pixel and the original RGB stream, and aligns the two through a pixel-enable delay line.
- Produces the display pixel in one of four view modes: pass-through, edge grey, colour overlay or binary.
- Accumulates per-frame edge statistics: edge count and bounding box. These are published once per frame for the control/HUD logic.

Parameters:
- DELAY, 2, pixel-enable steps applied to RGB/col/row to align them with edge_in (legal range 1..4).
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- OVL_COLOR, 24'hFF0000, overlay colour {r,g,b} used in mode 2.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  one pixel step; all pipeline state advances only when high
- col  in  13  column of incoming r/g/b
- row  in  13  row of incoming r/g/b
- r, g, b  in  8 each  raw pixel
- edge_in  in  8  edge magnitude; corresponds to the pixel DELAY steps earlier
- mode  in  2  0 pass-through, 1 edge grey, 2 overlay, 3 binary
- thresh  in  8  edge threshold; sampled at frame start
- r_out, g_out, b_out  out  8 each  display pixel
- out_valid  out  1  high one cycle after a pix_en whose delayed coordinate is in the active area
- edge_count  out  20  edges in last completed frame
- x_min, x_max, y_min, y_max  out  13 each  bounding box of last frame's edges
- stats_valid  out  1  one-cycle pulse when the stats outputs update

Behaviour:
- Reset (synchronous, active-high, clk rising edge): all outputs 0, delay line cleared, FSM to IDLE, thr_q = 0.
- Delay line:
  - DELAY-stage register chain of {r,g,b,col,row}, shifting only on pix_en.
  - Delayed values d_rgb, d_col, d_row pair with the current edge_in.
- Active test: act = (d_col < H_ACTIVE) && (d_row < V_ACTIVE).
- Hit: hit = act && (edge_in >= thr_q), where thr_q is the latched threshold.
- Output register (updates on a pix_en cycle, visible the next clk; latency 1 clk after pix_en):
  - mode 0: d_rgb.
  - mode 1: {edge_in, edge_in, edge_in}.
  - mode 2: OVL_COLOR if hit, else d_rgb.
  - mode 3: 24'hFFFFFF if hit, else 0.
  - Not act: output 0.
  - out_valid = act on pix_en cycles, 0 otherwise.
  - mode is sampled live per pixel.
- Stats FSM states: IDLE, ACCUM, PUBLISH.
- IDLE:
  - Waits for pix_en with d_col==0 && d_row==0 (frame start).
  - On frame start: thr_q <= thresh, count <= hit, bbox <= empty; that pixel is accumulated; go to ACCUM.
- ACCUM, on each pix_en with hit:
  - count increments, saturating at 20'hFFFFF.
  - First hit of the frame loads x_min=x_max=d_col, y_min=y_max=d_row.
  - Later hits update min/max.
- Resync inside ACCUM:
  - A frame start re-initialises exactly as from IDLE.
  - The partial frame is discarded with no stats_valid.
- End of frame in ACCUM:
  - pix_en at d_col==H_ACTIVE-1 && d_row==V_ACTIVE-1 accumulates that pixel and goes to PUBLISH.
- PUBLISH (exactly one clk):
  - Copy count and bbox to the outputs; stats_valid=1; go to IDLE.
  - A frame with zero hits publishes edge_count=0 and all bbox outputs 0.
- Stats outputs hold between publishes.
- pix_en low: no delay-line, stats or output-pixel change; out_valid=0.
- thresh changes mid-frame have no effect until the next frame start.
- Reset mid-frame discards all state. The first publish after reset requires a full frame starting at (0,0).

Test Plan:
- Reset mid-frame, then rst held 2 clks -> all outputs 0; no stats_valid until a full frame from (0,0).
- DELAY=2, pix_en every clk, mode 0, RGB ramp r=col[7:0] -> r_out sequence lags input by 2 pix_en plus 1 clk; out_valid low for col>=640.
- Mode 2, thresh=64, edge_in=64 at pixel (10,5) and 63 elsewhere -> only (10,5) shows FF0000; mode 3 shows FFFFFF there, 0 elsewhere.
- Full 640x480 frame with hits at (3,7), (600,2), (100,470) -> stats_valid pulses once one clk after last pixel; edge_count=3, x_min=3, x_max=600, y_min=2, y_max=470.
- All-zero edge frame after a populated frame -> edge_count=0, bbox all 0; thresh changed mid-frame from 64 to 0 does not alter the count until next frame.
- Frame start injected mid-ACCUM, and pix_en gapped 1-in-3 -> no stats_valid for the aborted frame; results are identical to the ungapped run.
